tlul_mem_responder: RTL and testbench
=====================================

TLUL_MEM_RESPONDER -- requirements
Module: tlul_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width; only 32 is supported.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports a_valid_i (input, 1) and a_ready_o (output, 1): the A-channel handshake.
REQ-006 SHALL have port a_opcode_i, input, 3 bits: PutFullData=0, PutPartialData=1, Get=4.
REQ-007 SHALL have ports a_size_i (input, 2: log2 bytes), a_address_i (input, ADDR_W), a_mask_i (input, 4) and a_data_i (input, DATA_W, lane-aligned).
REQ-008 SHALL have ports d_valid_o (output, 1) and d_ready_i (input, 1): the D-channel handshake.
REQ-009 SHALL have ports d_opcode_o (output, 3: AccessAck=0, AccessAckData=1), d_size_o (output, 2), d_data_o (output, DATA_W, right-justified) and d_error_o (output, 1).
REQ-010 SHALL have memory ports mem_req_o (out, 1), mem_we_o (out, 1), mem_addr_o (out, ADDR_W, word-aligned), mem_be_o (out, 4), mem_wdata_o (out, DATA_W) and mem_rdata_i (in, DATA_W, valid one cycle after mem_req_o).

Function
REQ-011 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-012 SHALL drive a_ready_o=1 only in IDLE; an A beat is accepted when a_valid_i & a_ready_o, and the request is latched on acceptance.
REQ-013 SHALL transition IDLE->ACCESS on acceptance, ACCESS->RESP unconditionally after one cycle, RESP->IDLE when d_ready_i=1, and otherwise hold RESP.
REQ-014 SHALL assert mem_req_o for exactly the one ACCESS cycle, with mem_we_o=1 for Put opcodes, mem_addr_o={addr[ADDR_W-1:2],2'b00} and mem_wdata_o=latched a_data_i.
REQ-015 SHALL set mem_be_o from a_mask_i for PutPartialData; for Get and PutFullData it SHALL be derived from size and address: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; size 2 -> 4'b1111.
REQ-016 SHALL capture mem_rdata_i on the ACCESS->RESP edge, shift it right by addr[1:0]*8, zero-fill the upper bits, and present the result on d_data_o.
REQ-017 SHALL respond to Get with d_opcode_o=1, and to Puts with d_opcode_o=0 and d_data_o=0; d_size_o SHALL equal the latched a_size_i.
REQ-018 SHALL assert d_valid_o throughout RESP only, and hold all D outputs stable while d_valid_o=1 and d_ready_i=0.
REQ-019 SHALL have a latency of acceptance at cycle N, mem_req_o at N+1 and d_valid_o at N+2; the next accept is possible in the cycle after the D handshake, giving a maximum throughput of one transaction per 3 cycles.
REQ-020 SHALL ignore a_valid_i outside IDLE; the A fields need not be stable once accepted.

Reset
REQ-021 SHALL, while rst_ni=0, force state=IDLE, a_ready_o=0, d_valid_o=0, mem_req_o=0, mem_we_o=0, and set d_opcode_o, d_size_o, d_data_o, d_error_o, mem_be_o, mem_addr_o and mem_wdata_o to 0.
REQ-022 SHALL, after rst_ni deasserts, assert a_ready_o from the first clock edge onward.
REQ-023 SHALL, on a reset asserted mid-ACCESS or mid-RESP, drop the transaction without a response and deassert mem_req_o and d_valid_o immediately (asynchronously).

Configuration
REQ-024 SHALL, with TLUL_ERR_CHECK_EN defined, flag as an error any of: a_size_i=3; size 1 with addr[0]=1; size 2 with addr[1:0]!=0; or an opcode not in {0,1,4}.
REQ-025 SHALL, on a flagged error, skip the memory access (mem_req_o stays 0), keep the same IDLE->ACCESS->RESP timing, and respond with d_error_o=1, d_data_o=0 and d_opcode_o=1 for Get, 0 otherwise.
REQ-026 SHALL, without TLUL_ERR_CHECK_EN, tie d_error_o to 0, perform no checks, and pass every request to memory.

Structure
REQ-027 SHALL take from the shared package tlul_pkg: the A/D opcode constants as a typedef enum, the FSM state typedef, and a function computing the byte-enable from size and address.
REQ-028 SHALL be a single module with no sub-modules; the memory is external.

Verification
REQ-029 SHALL be verified by: Get, size 2, addr 0x100, memory word 0xDEADBEEF -> mem_req_o at N+1 and d_valid_o at N+2 with d_opcode_o=1 and d_data_o=0xDEADBEEF.
REQ-030 SHALL be verified by: Get, size 0, addr 0x103, memory word 0xAABBCCDD -> mem_be_o=4'b1000 and d_data_o=0x000000AA.
REQ-031 SHALL be verified by: PutPartialData, addr 0x20, mask 4'b0110, data 0x11223344 -> mem_we_o=1, mem_be_o=4'b0110, mem_wdata_o=0x11223344, and the response has d_opcode_o=0 and d_data_o=0.
REQ-032 SHALL be verified by: holding d_ready_i=0 for 5 cycles in RESP with a_valid_i=1 throughout -> d_valid_o and D data stay stable, a_ready_o=0, and the next request is accepted the cycle after the D handshake.
REQ-033 SHALL be verified by, with TLUL_ERR_CHECK_EN defined: Get, size 2, addr 0x102 -> no mem_req_o, d_error_o=1 and d_data_o=0; without the macro, the same stimulus -> mem_req_o=1 and d_error_o=0.
REQ-034 SHALL be verified by: rst_ni pulled low in RESP -> d_valid_o=0 immediately, and a_ready_o=1 on the first edge after release.

Source files
------------

// File: rtl/tlul_pkg.sv
// Shared TL-UL types: A/D opcodes, responder FSM states and the byte-enable helper.
package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'd0,
      PutPartialData = 3'd1,
      Get            = 3'd4
   } tlAOp_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'd0,
      AccessAckData = 3'd1
   } tlDOp_e;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } rspState_e;

   // Lanes touched by a naturally sized access; oversize shifts simply fall off the top.
   function automatic logic [3:0] calcByteEnable(input logic [1:0] size, input logic [1:0] addrLow);
      case (size)
         2'd0:    calcByteEnable = 4'b0001 << addrLow;
         2'd1:    calcByteEnable = 4'b0011 << addrLow;
         default: calcByteEnable = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/tlul_mem_responder.sv
// Single-outstanding TL-UL responder in front of an external one-cycle SRAM port.
// Define TLUL_ERR_CHECK_EN to answer malformed requests with d_error_o instead of accessing memory.
module tlul_mem_responder
   import tlul_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              a_valid_i,
   output logic              a_ready_o,
   input  logic [2:0]        a_opcode_i,
   input  logic [1:0]        a_size_i,
   input  logic [ADDR_W-1:0] a_address_i,
   input  logic [3:0]        a_mask_i,
   input  logic [DATA_W-1:0] a_data_i,
   output logic              d_valid_o,
   input  logic              d_ready_i,
   output logic [2:0]        d_opcode_o,
   output logic [1:0]        d_size_o,
   output logic [DATA_W-1:0] d_data_o,
   output logic              d_error_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   rspState_e         state_q;
   logic              aReady_q, dValid_q, dError_q, memReq_q, memWe_q;
   logic [2:0]        dOpcode_q;
   logic [1:0]        dSize_q, size_q, offset_q;
   logic [DATA_W-1:0] dData_q, memWdata_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [3:0]        memBe_q;
   logic              isGet_q, err_q;

   logic              isPut_d, isGet_d, err_d;
   logic [3:0]        be_d;
   logic [DATA_W-1:0] rdataAligned;

   always_comb begin
      isPut_d = (a_opcode_i == PutFullData) || (a_opcode_i == PutPartialData);
      isGet_d = (a_opcode_i == Get);
      be_d    = (a_opcode_i == PutPartialData) ? a_mask_i
                                               : calcByteEnable(a_size_i, a_address_i[1:0]);
`ifdef TLUL_ERR_CHECK_EN
      err_d   = (a_size_i == 2'd3)
             || ((a_size_i == 2'd1) && a_address_i[0])
             || ((a_size_i == 2'd2) && (a_address_i[1:0] != 2'b00))
             || !(isPut_d || isGet_d);
`else
      err_d   = 1'b0;
`endif
   end

   assign rdataAligned = mem_rdata_i >> {offset_q, 3'b000};

   // Every output is a flop, so reset clears them asynchronously and the D beat is glitch-free.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         aReady_q   <= 1'b0;
         dValid_q   <= 1'b0;
         dOpcode_q  <= '0;
         dSize_q    <= '0;
         dData_q    <= '0;
         dError_q   <= 1'b0;
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memBe_q    <= '0;
         memWdata_q <= '0;
         size_q     <= '0;
         offset_q   <= '0;
         isGet_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               aReady_q <= 1'b1;
               if (a_valid_i && aReady_q) begin
                  state_q    <= ACCESS;
                  aReady_q   <= 1'b0;
                  memReq_q   <= !err_d;
                  memWe_q    <= isPut_d && !err_d;
                  memAddr_q  <= {a_address_i[ADDR_W-1:2], 2'b00};
                  memBe_q    <= be_d;
                  memWdata_q <= a_data_i;
                  size_q     <= a_size_i;
                  offset_q   <= a_address_i[1:0];
                  isGet_q    <= isGet_d;
                  err_q      <= err_d;
               end
            end
            ACCESS: begin
               state_q   <= RESP;
               memReq_q  <= 1'b0;
               memWe_q   <= 1'b0;
               dValid_q  <= 1'b1;
               dOpcode_q <= isGet_q ? AccessAckData : AccessAck;
               dSize_q   <= size_q;
               dError_q  <= err_q;
               dData_q   <= (isGet_q && !err_q) ? rdataAligned : '0;
            end
            RESP: begin
               if (d_ready_i) begin
                  state_q  <= IDLE;
                  dValid_q <= 1'b0;
                  aReady_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_ready_o   = aReady_q;
   assign d_valid_o   = dValid_q;
   assign d_opcode_o  = dOpcode_q;
   assign d_size_o    = dSize_q;
   assign d_data_o    = dData_q;
   assign d_error_o   = dError_q;
   assign mem_req_o   = memReq_q;
   assign mem_we_o    = memWe_q;
   assign mem_addr_o  = memAddr_q;
   assign mem_be_o    = memBe_q;
   assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Scoreboard bench for tlul_mem_responder: expected D beats are queued at request time and popped on d_valid_o.
// Build with TLUL_ERR_CHECK_EN defined to exercise the error-checking variant.
module tb_tlul_mem_responder;
   import tlul_pkg::*;

   typedef struct packed {
      logic [2:0]  op;
      logic [1:0]  size;
      logic [31:0] data;
      logic        err;
   } dBeat_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        a_valid_i = 1'b0;
   logic        a_ready_o;
   logic [2:0]  a_opcode_i = '0;
   logic [1:0]  a_size_i = '0;
   logic [31:0] a_address_i = '0;
   logic [3:0]  a_mask_i = '0;
   logic [31:0] a_data_i = '0;
   logic        d_valid_o;
   logic        d_ready_i = 1'b1;
   logic [2:0]  d_opcode_o;
   logic [1:0]  d_size_o;
   logic [31:0] d_data_o;
   logic        d_error_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   int     checks = 0;
   int     fails = 0;
   int     cycleCnt = 0;
   dBeat_t expQ[$];

   logic [31:0] memArr [0:255];
   logic        plWe = 1'b0;
   logic [7:0]  plIdx = '0;
   logic [31:0] plData = '0;

   tlul_mem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
      .a_size_i(a_size_i), .a_address_i(a_address_i), .a_mask_i(a_mask_i), .a_data_i(a_data_i),
      .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
      .d_size_o(d_size_o), .d_data_o(d_data_o), .d_error_o(d_error_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Behavioural SRAM: read data follows the address combinationally, writes and preloads land on the edge.
   assign mem_rdata_i = memArr[mem_addr_o[9:2]];
   always @(posedge clk) begin
      if (plWe) memArr[plIdx] <= plData;
      else if (mem_req_o && mem_we_o)
         for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) memArr[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
   end

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      plWe = 1'b1; plIdx = idx; plData = val;
      @(negedge clk);
      plWe = 1'b0;
   endtask

   // Presents one A beat from a negedge; returns at the negedge of the ACCESS cycle with A fields scrambled.
   task automatic sendReq(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data,
                          output bit accepted, output int acceptCycle);
      int w = 0;
      a_valid_i = 1'b1; a_opcode_i = op; a_size_i = sz;
      a_address_i = addr; a_mask_i = mask; a_data_i = data;
      while (a_ready_o !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      accepted = (a_ready_o === 1'b1);
      acceptCycle = cycleCnt;
      @(negedge clk);
      a_valid_i = 1'b0;
      a_opcode_i = 3'($urandom); a_size_i = 2'($urandom);
      a_address_i = $urandom; a_mask_i = 4'($urandom); a_data_i = $urandom;
   endtask

   task automatic waitResp(output bit seen);
      int n = 0;
      while (d_valid_o !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      seen = (d_valid_o === 1'b1);
   endtask

   task automatic test_reset();
      #3 rst_ni = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({a_ready_o, d_valid_o, d_opcode_o, d_size_o, d_data_o, d_error_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: a_ready=%b d_valid=%b mem_req=%b d_data=%h mem_addr=%h, all required 0",
                  a_ready_o, d_valid_o, mem_req_o, d_data_o, mem_addr_o);
      end
      rst_ni = 1'b1;
      checks++;
      if (a_ready_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_release_pre_edge: a_ready=%b required 0", a_ready_o);
      end
      @(negedge clk);
      checks++;
      if (a_ready_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_first_edge_ready: a_ready=%b required 1", a_ready_o);
      end
   endtask

   task automatic test_get_word();
      bit acc, seen;
      int c;
      dBeat_t exp, obs;
      preload(8'h40, 32'hDEADBEEF);
      expQ.push_back(dBeat_t'{op: 3'd1, size: 2'd2, data: 32'hDEADBEEF, err: 1'b0});
      sendReq(3'd4, 2'd2, 32'h100, 4'hF, 32'h0, acc, c);
      checks++;
      if (!acc || {mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
         fails++;
         $display("[TB] FAIL get_word_access: acc=%b req=%b we=%b be=%b addr=%h, required 1 1 0 1111 00000100",
                  acc, mem_req_o, mem_we_o, mem_be_o, mem_addr_o);
      end
      @(negedge clk);
      checks++;
      if (d_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL get_word_latency: d_valid=%b mem_req=%b at N+2, required 1 0", d_valid_o, mem_req_o);
      end
      waitResp(seen);
      exp = expQ.pop_front();
      obs = {d_opcode_o, d_size_o, d_data_o, d_error_o};
      checks++;
      if (!seen || obs !== exp) begin
         fails++;
         $display("[TB] FAIL get_word_resp: got %h required %h", obs, exp);
      end
      @(negedge clk);
      checks++;
      if (d_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL get_word_release: d_valid=%b a_ready=%b required 0 1", d_valid_o, a_ready_o);
      end
   endtask

   task automatic test_get_byte();
      bit acc, seen;
      int c;
      dBeat_t exp, obs;
      preload(8'h40, 32'hAABBCCDD);
      expQ.push_back(dBeat_t'{op: 3'd1, size: 2'd0, data: 32'h000000AA, err: 1'b0});
      sendReq(3'd4, 2'd0, 32'h103, 4'h0, 32'h0, acc, c);
      checks++;
      if (!acc || mem_req_o !== 1'b1 || mem_be_o !== 4'b1000 || mem_addr_o !== 32'h100) begin
         fails++;
         $display("[TB] FAIL get_byte_be: acc=%b req=%b be=%b addr=%h required 1 1 1000 00000100",
                  acc, mem_req_o, mem_be_o, mem_addr_o);
      end
      waitResp(seen);
      exp = expQ.pop_front();
      obs = {d_opcode_o, d_size_o, d_data_o, d_error_o};
      checks++;
      if (!seen || obs !== exp) begin
         fails++;
         $display("[TB] FAIL get_byte_resp: got %h required %h", obs, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_put_partial();
      bit acc, seen;
      int c;
      dBeat_t exp, obs;
      preload(8'h08, 32'hFFFFFFFF);
      expQ.push_back(dBeat_t'{op: 3'd0, size: 2'd2, data: 32'h0, err: 1'b0});
      sendReq(3'd1, 2'd2, 32'h20, 4'b0110, 32'h11223344, acc, c);
      checks++;
      if (!acc || {mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o} !==
                  {1'b1, 1'b1, 4'b0110, 32'h11223344, 32'h20}) begin
         fails++;
         $display("[TB] FAIL put_partial_access: req=%b we=%b be=%b wdata=%h addr=%h required 1 1 0110 11223344 00000020",
                  mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o);
      end
      waitResp(seen);
      exp = expQ.pop_front();
      obs = {d_opcode_o, d_size_o, d_data_o, d_error_o};
      checks++;
      if (!seen || obs !== exp) begin
         fails++;
         $display("[TB] FAIL put_partial_resp: got %h required %h", obs, exp);
      end
      @(negedge clk);
      expQ.push_back(dBeat_t'{op: 3'd1, size: 2'd2, data: 32'hFF2233FF, err: 1'b0});
      sendReq(3'd4, 2'd2, 32'h20, 4'h0, 32'h0, acc, c);
      waitResp(seen);
      exp = expQ.pop_front();
      obs = {d_opcode_o, d_size_o, d_data_o, d_error_o};
      checks++;
      if (!acc || !seen || obs !== exp) begin
         fails++;
         $display("[TB] FAIL put_partial_readback: got %h required %h", obs, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit acc, seen;
      int c;
      dBeat_t exp, obs;
      preload(8'h10, 32'h12345678);
      d_ready_i = 1'b0;
      expQ.push_back(dBeat_t'{op: 3'd1, size: 2'd1, data: 32'h00001234, err: 1'b0});
      sendReq(3'd4, 2'd1, 32'h42, 4'h0, 32'h0, acc, c);
      checks++;
      if (!acc || mem_be_o !== 4'b1100) begin
         fails++;
         $display("[TB] FAIL bp_be: acc=%b be=%b required 1 1100", acc, mem_be_o);
      end
      a_valid_i = 1'b1; a_opcode_i = 3'd0; a_size_i = 2'd2;
      a_address_i = 32'h44; a_mask_i = 4'hF; a_data_i = 32'h0BADF00D;
      expQ.push_back(dBeat_t'{op: 3'd0, size: 2'd2, data: 32'h0, err: 1'b0});
      @(negedge clk);
      exp = expQ.pop_front();
      for (int i = 0; i < 5; i++) begin
         obs = {d_opcode_o, d_size_o, d_data_o, d_error_o};
         checks++;
         if (d_valid_o !== 1'b1 || a_ready_o !== 1'b0 || mem_req_o !== 1'b0 || obs !== exp) begin
            fails++;
            $display("[TB] FAIL bp_hold[%0d]: d_valid=%b a_ready=%b mem_req=%b beat=%h required 1 0 0 %h",
                     i, d_valid_o, a_ready_o, mem_req_o, obs, exp);
         end
         @(negedge clk);
      end
      d_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (d_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL bp_handshake: d_valid=%b a_ready=%b required 0 1", d_valid_o, a_ready_o);
      end
      @(negedge clk);
      a_valid_i = 1'b0;
      checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 32'h44, 32'h0BADF00D}) begin
         fails++;
         $display("[TB] FAIL bp_next_accept: req=%b we=%b addr=%h wdata=%h required 1 1 00000044 0badf00d",
                  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      waitResp(seen);
      exp = expQ.pop_front();
      obs = {d_opcode_o, d_size_o, d_data_o, d_error_o};
      checks++;
      if (!seen || obs !== exp) begin
         fails++;
         $display("[TB] FAIL bp_second_resp: got %h required %h", obs, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_err_check();
      bit acc, seen;
      int c;
      dBeat_t exp, obs;
      logic [2:0] ops [2];
      logic       expReq [2];
      dBeat_t     expBeat [2];
      ops[0] = 3'd4;
      ops[1] = 3'd3;
`ifdef TLUL_ERR_CHECK_EN
      expReq[0] = 1'b0; expBeat[0] = dBeat_t'{op: 3'd1, size: 2'd2, data: 32'h0, err: 1'b1};
      expReq[1] = 1'b0; expBeat[1] = dBeat_t'{op: 3'd0, size: 2'd2, data: 32'h0, err: 1'b1};
`else
      expReq[0] = 1'b1; expBeat[0] = dBeat_t'{op: 3'd1, size: 2'd2, data: 32'h0000CAFE, err: 1'b0};
      expReq[1] = 1'b1; expBeat[1] = dBeat_t'{op: 3'd0, size: 2'd2, data: 32'h0, err: 1'b0};
`endif
      preload(8'h40, 32'hCAFEF00D);
      for (int i = 0; i < 2; i++) begin
         expQ.push_back(expBeat[i]);
         sendReq(ops[i], 2'd2, 32'h102, 4'hF, 32'h0, acc, c);
         checks++;
         if (!acc || mem_req_o !== expReq[i] || mem_we_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_mem_req[%0d]: acc=%b req=%b we=%b required 1 %b 0",
                     i, acc, mem_req_o, mem_we_o, expReq[i]);
         end
         @(negedge clk);
         waitResp(seen);
         exp = expQ.pop_front();
         obs = {d_opcode_o, d_size_o, d_data_o, d_error_o};
         checks++;
         if (!seen || obs !== exp) begin
            fails++;
            $display("[TB] FAIL err_resp[%0d]: got %h required %h", i, obs, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      bit acc, seen;
      int c, prevC;
      dBeat_t exp, obs;
      logic [2:0]  op   [5] = '{3'd0, 3'd4, 3'd4, 3'd0, 3'd4};
      logic [1:0]  sz   [5] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0};
      logic [31:0] ad   [5] = '{32'h201, 32'h200, 32'h202, 32'h204, 32'h206};
      logic [31:0] wd   [5] = '{32'h0000AB00, 32'h0, 32'h0, 32'h55667788, 32'h0};
      logic [31:0] rd   [5] = '{32'h0, 32'h1111AB11, 32'h00001111, 32'h0, 32'h00005566};
      logic [3:0]  be   [5] = '{4'b0010, 4'b1111, 4'b1100, 4'b1111, 4'b0100};
      preload(8'h80, 32'h11111111);
      prevC = 0;
      for (int i = 0; i < 5; i++) begin
         expQ.push_back(dBeat_t'{op: (op[i] == 3'd4) ? 3'd1 : 3'd0, size: sz[i], data: rd[i], err: 1'b0});
         sendReq(op[i], sz[i], ad[i], 4'hF, wd[i], acc, c);
         checks++;
         if (!acc || mem_be_o !== be[i] || (i > 0 && c - prevC != 3)) begin
            fails++;
            $display("[TB] FAIL b2b_accept[%0d]: acc=%b be=%b spacing=%0d required 1 %b 3",
                     i, acc, mem_be_o, c - prevC, be[i]);
         end
         prevC = c;
         @(negedge clk);
         waitResp(seen);
         exp = expQ.pop_front();
         obs = {d_opcode_o, d_size_o, d_data_o, d_error_o};
         checks++;
         if (!seen || obs !== exp) begin
            fails++;
            $display("[TB] FAIL b2b_resp[%0d]: got %h required %h", i, obs, exp);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_in_resp();
      bit acc;
      int c;
      d_ready_i = 1'b0;
      sendReq(3'd4, 2'd2, 32'h100, 4'hF, 32'h0, acc, c);
      @(negedge clk);
      checks++;
      if (!acc || d_valid_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL rst_resp_setup: acc=%b d_valid=%b required 1 1", acc, d_valid_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (d_valid_o !== 1'b0 || mem_req_o !== 1'b0 || a_ready_o !== 1'b0 || d_data_o !== 32'h0) begin
         fails++;
         $display("[TB] FAIL rst_resp_async: d_valid=%b mem_req=%b a_ready=%b d_data=%h required 0 0 0 0",
                  d_valid_o, mem_req_o, a_ready_o, d_data_o);
      end
      d_ready_i = 1'b1;
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      checks++;
      if (a_ready_o !== 1'b1 || d_valid_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL rst_resp_recover: a_ready=%b d_valid=%b required 1 0", a_ready_o, d_valid_o);
      end
      checks++;
      if (expQ.size() != 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_drain: %0d beats left required 0", expQ.size());
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_get_word();
      test_get_byte();
      test_put_partial();
      test_backpressure();
      test_err_check();
      test_back_to_back();
      test_reset_in_resp();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
